uart_transceiver_core: RTL and testbench
========================================

# uart_transceiver_core

Full-duplex 8N1 UART transceiver with a 16x-oversampling baud generator programmed by a runtime divisor. It sits between the SoC's byte-level host logic and the serial pins, for example as the bench-side terminal attached to the SoC UART. It accepts single-cycle write strobes for transmit and reports received bytes with single-cycle done pulses.

## Interface
- No parameters. The divisor is a port, so the baud rate can change at runtime.
- sys_clk  in  1  System clock. All logic is on the rising edge.
- sys_rst  in  1  Reset, asynchronous and active-high.
- uart_rx  in  1  Serial input. Asynchronous to sys_clk and idle-high.
- uart_tx  out  1  Serial output, idle-high.
- divisor  in  16  Number of sys_clk cycles per oversample tick. Baud = f_clk / (16 × divisor). Valid range is 1..65535.
- rx_data  out  8  Last received byte. Held until the next successful reception.
- rx_done  out  1  One-cycle pulse: rx_data has just been updated with a valid frame.
- tx_data  in  8  Byte to send. Sampled on the cycle tx_wr is high.
- tx_wr  in  1  One-cycle transmit request.
- tx_done  out  1  One-cycle pulse at the end of the stop bit.
- rx_break  out  1  One-cycle pulse: a break condition was detected (frame of all zeros with a low stop bit).

## Operation
- **Tick generator**
  - 16-bit down-counter, reloaded with divisor-1.
  - `tick` is high for one cycle when the counter reads 0.
  - Both RX and TX advance only on `tick`.
- **RX synchronizer**
  - uart_rx passes through two flip-flops, giving `rx_s`.
  - `rx_r` is the registered previous value of `rx_s`.
- **RX state**
  - State is `rx_busy`, a 4-bit `rx_cnt16`, a 4-bit `rx_bitcnt` and an 8-bit shift register.
  - Idle, on tick with `rx_s`=0: set busy, cnt16=0, bitcnt=0.
  - Busy, on tick: cnt16 increments. When cnt16==7 (the bit centre):
    - bitcnt 0: if `rx_s`=1 (false start), return to idle. Otherwise bitcnt=1.
    - bitcnt 1..8: shift `rx_s` in at the MSB, so the byte is received LSB first. Then bitcnt++.
    - bitcnt 9 (stop bit): return to idle.
      - If `rx_s`=1: load rx_data from the shift register and pulse rx_done.
      - Else if the shift register is 0x00: pulse rx_break.
      - Otherwise it is a framing error and the frame is dropped silently.
- **TX state**
  - State is `tx_busy`, a 4-bit `tx_cnt16`, a 4-bit `tx_bitcnt` and a 9-bit shift register.
  - Idle with tx_wr=1: latch {1'b1, tx_data}, drive uart_tx=0 (start bit), set busy, cnt16=0, bitcnt=0.
  - tx_wr while busy is ignored. The caller must wait for tx_done.
  - Busy, on tick: cnt16++. At cnt16==15:
    - If bitcnt<9: drive uart_tx from the shift LSB, shift right, bitcnt++. This emits data bits 0..7, then the stop bit.
    - If bitcnt==9: clear busy and pulse tx_done. uart_tx stays 1.
- TX and RX are fully independent. Loopback works with simultaneous activity.

## Timing
- **Reset values:** uart_tx=1, rx_data=0x00, rx_done=0, tx_done=0, rx_break=0, all counters 0, both engines idle. Reset in mid-frame aborts the frame immediately and uart_tx returns to 1.
- **Bit period:** 16 × divisor clocks.
- **TX latency:**
  - uart_tx goes low the cycle after tx_wr.
  - Frame length is 10 bit periods, ±1 tick for the phase of the free-running tick counter.
  - tx_done fires about 10 bit periods after tx_wr.
- **RX latency:** rx_done fires about 9.5 bit periods after the start edge, plus 2–3 cycles of synchronizer delay.
- **Tick counter:** free-running. A divisor change takes effect at the next reload.
- **Pulse rule:** rx_done, tx_done and rx_break are each high for exactly one sys_clk cycle, never back-to-back for the same frame.
- **Glitch rejection:** a low glitch shorter than half a bit on idle uart_rx produces no rx_done.

## Structure
- Package `uart_pkg` holds:
  - `UART_OVERSAMPLE=16`
  - `UART_DATA_BITS=8`
  - `UART_SAMPLE_POINT=7`
  - `UART_FRAME_BITS=10`
- One sub-module: `uart_baud_gen`, the divisor counter that produces `tick`.
- RX and TX are two always_ff processes in the top block. Estimated size is about 180 lines.

## Test plan
- **Reset:** assert sys_rst mid-TX -> uart_tx=1, tx_done never fires, all outputs at reset values.
- **TX:** divisor=2, tx_wr with 0xA5 -> uart_tx emits 0, then 1,0,1,0,0,1,0,1, then 1, each held 32 cycles. tx_done fires once about 320 cycles later.
- **Loopback:** uart_tx tied to uart_rx, divisor=43, send 0x55 then 0x00 then 0xFF (each after tx_done) -> rx_done with rx_data=0x55, 0x00, 0xFF in order.
- **Busy write:** tx_wr with 0x12, then tx_wr with 0x34 during the frame -> only 0x12 is transmitted and exactly one tx_done.
- **Break:** drive uart_rx low for 12 bit periods -> rx_break pulses once, no rx_done, rx_data unchanged.
- **Framing and glitch:**
  - Frame 0x3C with a low stop bit -> no rx_done, no rx_break.
  - A 4-clock low glitch at divisor=2 -> no rx_done.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the 8N1 UART transceiver: oversampling ratio and frame geometry.
package uart_pkg;

  localparam int unsigned UART_OVERSAMPLE   = 16;
  localparam int unsigned UART_DATA_BITS    = 8;
  localparam int unsigned UART_SAMPLE_POINT = 7;
  localparam int unsigned UART_FRAME_BITS   = 10;

  typedef logic [3:0] uart_cnt_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running oversample tick generator: one-cycle tick every divisor clocks.
module uart_baud_gen (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [15:0] divisor,
  output logic        tick
);

  logic [15:0] cnt_q;

  assign tick = (cnt_q == 16'd0);

  // A new divisor is only picked up on reload, so the current period always completes.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_q <= 16'd0;
    end else if (tick) begin
      cnt_q <= divisor - 16'd1;
    end else begin
      cnt_q <= cnt_q - 16'd1;
    end
  end

endmodule

// File: rtl/uart_transceiver_core.sv
// Full-duplex 8N1 UART with independent RX and TX engines sharing one 16x oversample tick.
module uart_transceiver_core
  import uart_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        uart_rx,
  output logic        uart_tx,
  input  logic [15:0] divisor,
  output logic [7:0]  rx_data,
  output logic        rx_done,
  input  logic [7:0]  tx_data,
  input  logic        tx_wr,
  output logic        tx_done,
  output logic        rx_break
);

  localparam uart_cnt_t SampleCnt = uart_cnt_t'(UART_SAMPLE_POINT);
  localparam uart_cnt_t LastCnt   = uart_cnt_t'(UART_OVERSAMPLE - 1);
  localparam uart_cnt_t DataBits  = uart_cnt_t'(UART_DATA_BITS);
  localparam uart_cnt_t StopIdx   = uart_cnt_t'(UART_FRAME_BITS - 1);

  logic tick;

  uart_baud_gen u_baud_gen (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .divisor (divisor),
    .tick    (tick)
  );

  // Two-flop synchronizer; resets to the idle-high line level.
  logic rx_meta_q, rx_s_q;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  logic       rx_busy_q;
  uart_cnt_t  rx_cnt16_q, rx_bitcnt_q;
  logic [7:0] rx_shift_q, rx_data_q;
  logic       rx_done_q, rx_break_q;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rx_busy_q   <= 1'b0;
      rx_cnt16_q  <= '0;
      rx_bitcnt_q <= '0;
      rx_shift_q  <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_done_q   <= 1'b0;
      rx_break_q  <= 1'b0;
    end else begin
      rx_done_q  <= 1'b0;
      rx_break_q <= 1'b0;
      if (tick) begin
        if (!rx_busy_q) begin
          if (!rx_s_q) begin
            rx_busy_q   <= 1'b1;
            rx_cnt16_q  <= '0;
            rx_bitcnt_q <= '0;
          end
        end else begin
          rx_cnt16_q <= rx_cnt16_q + 4'd1;
          if (rx_cnt16_q == SampleCnt) begin
            if (rx_bitcnt_q == '0) begin
              // Start bit must still be low at its centre, otherwise it was a glitch.
              if (rx_s_q) begin
                rx_busy_q <= 1'b0;
              end else begin
                rx_bitcnt_q <= 4'd1;
              end
            end else if (rx_bitcnt_q <= DataBits) begin
              rx_shift_q  <= {rx_s_q, rx_shift_q[7:1]};
              rx_bitcnt_q <= rx_bitcnt_q + 4'd1;
            end else begin
              rx_busy_q <= 1'b0;
              if (rx_s_q) begin
                rx_data_q <= rx_shift_q;
                rx_done_q <= 1'b1;
              end else if (rx_shift_q == 8'h00) begin
                rx_break_q <= 1'b1;
              end
            end
          end
        end
      end
    end
  end

  logic       tx_busy_q;
  uart_cnt_t  tx_cnt16_q, tx_bitcnt_q;
  logic [8:0] tx_shift_q;
  logic       tx_q, tx_done_q;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      tx_busy_q   <= 1'b0;
      tx_cnt16_q  <= '0;
      tx_bitcnt_q <= '0;
      tx_shift_q  <= 9'h000;
      tx_q        <= 1'b1;
      tx_done_q   <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      if (!tx_busy_q) begin
        if (tx_wr) begin
          tx_shift_q  <= {1'b1, tx_data};
          tx_q        <= 1'b0;
          tx_busy_q   <= 1'b1;
          tx_cnt16_q  <= '0;
          tx_bitcnt_q <= '0;
        end
      end else if (tick) begin
        tx_cnt16_q <= tx_cnt16_q + 4'd1;
        if (tx_cnt16_q == LastCnt) begin
          // Shift register carries the stop bit in its MSB, so bit 9 leaves the line high.
          if (tx_bitcnt_q < StopIdx) begin
            tx_q        <= tx_shift_q[0];
            tx_shift_q  <= {1'b0, tx_shift_q[8:1]};
            tx_bitcnt_q <= tx_bitcnt_q + 4'd1;
          end else begin
            tx_busy_q <= 1'b0;
            tx_done_q <= 1'b1;
          end
        end
      end
    end
  end

  assign uart_tx  = tx_q;
  assign rx_data  = rx_data_q;
  assign rx_done  = rx_done_q;
  assign rx_break = rx_break_q;
  assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_transceiver_core.sv
// Self-checking bench: tick-count TX model plus an in-order RX byte scoreboard.
module tb_uart_transceiver_core;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        rx_drv  = 1'b1;
  logic        lb_en   = 1'b0;
  logic        tx_wr   = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic [15:0] divisor = 16'd2;
  logic        uart_rx, uart_tx, rx_done, tx_done, rx_break;
  logic [7:0]  rx_data;

  int total = 0;
  int bad   = 0;
  int rx_cnt = 0, brk_cnt = 0, txd_cnt = 0;
  logic [7:0] exp_q[$];

  assign uart_rx = lb_en ? uart_tx : rx_drv;

  always #5 sys_clk = ~sys_clk;

  uart_transceiver_core dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .uart_rx  (uart_rx),
    .uart_tx  (uart_tx),
    .divisor  (divisor),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .tx_data  (tx_data),
    .tx_wr    (tx_wr),
    .tx_done  (tx_done),
    .rx_break (rx_break)
  );

  // TX reference: the k-th edge after reset carries a tick when k % divisor == 0; a frame is
  // ten bits of sixteen ticks each, counted from the first tick after the accepted write.
  int         edge_k, m_ticks;
  logic       m_active, m_tx, m_done;
  logic [9:0] m_frame;

  always @(posedge sys_clk) begin
    if (sys_rst) begin
      edge_k   <= 0;
      m_ticks  <= 0;
      m_active <= 1'b0;
      m_tx     <= 1'b1;
      m_done   <= 1'b0;
    end else begin
      edge_k <= edge_k + 1;
      m_done <= 1'b0;
      if (!m_active) begin
        if (tx_wr) begin
          m_active <= 1'b1;
          m_ticks  <= 0;
          m_frame  <= {1'b1, tx_data, 1'b0};
          m_tx     <= 1'b0;
        end
      end else if (edge_k % int'(divisor) == 0) begin
        m_ticks <= m_ticks + 1;
        if ((m_ticks + 1) % 16 == 0) begin
          if ((m_ticks + 1) / 16 < 10) begin
            m_tx <= m_frame[(m_ticks + 1) / 16];
          end else begin
            m_done   <= 1'b1;
            m_active <= 1'b0;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    logic prev_rxd, prev_txd, prev_brk;
    prev_rxd = 1'b0;
    prev_txd = 1'b0;
    prev_brk = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (sys_rst) begin
        prev_rxd = 1'b0;
        prev_txd = 1'b0;
        prev_brk = 1'b0;
      end else begin
        chk("uart_tx_vs_model", 32'(uart_tx), 32'(m_tx));
        chk("tx_done_vs_model", 32'(tx_done), 32'(m_done));
        if (rx_done) begin
          rx_cnt++;
          if (exp_q.size() == 0) chk("rx_done_unexpected", 32'(rx_data), -1);
          else chk("rx_data_order", 32'(rx_data), 32'(exp_q.pop_front()));
        end
        if (rx_break) brk_cnt++;
        if (tx_done) txd_cnt++;
        if (rx_done && prev_rxd) chk("rx_done_one_cycle", 1, 0);
        if (tx_done && prev_txd) chk("tx_done_one_cycle", 1, 0);
        if (rx_break && prev_brk) chk("rx_break_one_cycle", 1, 0);
        prev_rxd = rx_done;
        prev_txd = tx_done;
        prev_brk = rx_break;
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic do_reset(input logic [15:0] d);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    divisor = d;
    cyc(3);
    sys_rst = 1'b0;
    cyc(2);
  endtask

  task automatic send(input logic [7:0] b, input bit expect_rx);
    tx_data = b;
    tx_wr   = 1'b1;
    @(negedge sys_clk);
    tx_wr   = 1'b0;
    if (expect_rx) exp_q.push_back(b);
  endtask

  task automatic wait_txd(input int budget, input string nm);
    int start, n;
    start = txd_cnt;
    n = 0;
    while (txd_cnt == start && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    chk(nm, 32'(txd_cnt != start), 1);
  endtask

  task automatic drive_frame(input logic [7:0] b, input bit stop, input int d);
    int bp;
    bp = 16 * d;
    rx_drv = 1'b0;
    cyc(bp);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      cyc(bp);
    end
    rx_drv = stop;
    if (stop) cyc(bp);
    else cyc(bp * 3 / 4);
    rx_drv = 1'b1;
    cyc(bp * 2);
  endtask

  initial begin
    int a5_bits[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    int n, t0, r0, b0;
    logic [7:0] rb;
    logic [15:0] d;

    fork
      monitor();
    join_none

    // Values held in reset
    lb_en = 1'b1;
    cyc(3);
    chk("rst_uart_tx", 32'(uart_tx), 1);
    chk("rst_rx_data", 32'(rx_data), 0);
    chk("rst_rx_done", 32'(rx_done), 0);
    chk("rst_tx_done", 32'(tx_done), 0);
    chk("rst_rx_break", 32'(rx_break), 0);
    sys_rst = 1'b0;
    cyc(5);

    // 0xA5 at divisor 2: mid-bit samples of a 32-cycle bit, then tx_done near 320 cycles
    send(8'hA5, 1'b1);
    for (int k = 0; k < 10; k++) begin
      cyc(k == 0 ? 16 : 32);
      chk($sformatf("a5_bit%0d", k), 32'(uart_tx), a5_bits[k]);
    end
    n = 304;
    while (!tx_done && n < 400) begin
      @(negedge sys_clk);
      n++;
    end
    chk("a5_tx_done_seen", 32'(tx_done), 1);
    chk("a5_tx_done_latency", 32'(n >= 312 && n <= 324), 1);
    cyc(40);
    chk("a5_loop_rx_data", 32'(rx_data), 32'h A5);

    // Write while busy is ignored
    t0 = txd_cnt;
    send(8'h12, 1'b1);
    cyc(100);
    send(8'h34, 1'b0);
    wait_txd(400, "busy_tx_done_timeout");
    cyc(400);
    chk("busy_one_tx_done", txd_cnt - t0, 1);
    chk("busy_rx_data", 32'(rx_data), 32'h12);
    chk("busy_rx_pending", exp_q.size(), 0);

    // Reset in mid-frame
    r0 = rx_cnt;
    send(8'h5A, 1'b0);
    cyc(100);
    sys_rst = 1'b1;
    cyc(1);
    chk("midrst_uart_tx", 32'(uart_tx), 1);
    chk("midrst_rx_data", 32'(rx_data), 0);
    chk("midrst_tx_done", 32'(tx_done), 0);
    cyc(2);
    sys_rst = 1'b0;
    t0 = txd_cnt;
    cyc(400);
    chk("midrst_no_tx_done", txd_cnt - t0, 0);
    chk("midrst_no_rx_done", rx_cnt - r0, 0);
    chk("midrst_uart_tx_idle", 32'(uart_tx), 1);

    // Randomized loopback, including divisor 1 and ignored mid-frame writes
    for (int p = 0; p < 2; p++) begin
      d = 16'($urandom_range(1, 4));
      do_reset(d);
      r0 = rx_cnt;
      for (int i = 0; i < 12; i++) begin
        rb = 8'($urandom);
        send(rb, 1'b1);
        if ($urandom_range(0, 1) == 1) begin
          cyc($urandom_range(1, 16 * int'(d) * 5));
          send(8'($urandom), 1'b0);
        end
        wait_txd(16 * int'(d) * 12, "rand_tx_done_timeout");
        cyc($urandom_range(0, 10));
      end
      cyc(16 * int'(d) * 2);
      chk("rand_rx_count", rx_cnt - r0, 12);
      chk("rand_rx_pending", exp_q.size(), 0);
    end

    // Loopback at divisor 43
    do_reset(16'd43);
    r0 = rx_cnt;
    send(8'h55, 1'b1);
    wait_txd(16 * 43 * 12, "lb55_timeout");
    send(8'h00, 1'b1);
    wait_txd(16 * 43 * 12, "lb00_timeout");
    send(8'hFF, 1'b1);
    wait_txd(16 * 43 * 12, "lbff_timeout");
    cyc(100);
    chk("lb43_rx_count", rx_cnt - r0, 3);
    chk("lb43_rx_pending", exp_q.size(), 0);
    chk("lb43_rx_data", 32'(rx_data), 32'hFF);

    // Break: line low for 12 bit periods
    lb_en  = 1'b0;
    r0     = rx_cnt;
    b0     = brk_cnt;
    rx_drv = 1'b0;
    cyc(12 * 16 * 43);
    rx_drv = 1'b1;
    cyc(16 * 43);
    chk("break_pulses", brk_cnt - b0, 1);
    chk("break_no_rx_done", rx_cnt - r0, 0);
    chk("break_rx_data_held", 32'(rx_data), 32'hFF);

    // Direct frames at divisor 4: good frame, then bad stop bit
    do_reset(16'd4);
    r0 = rx_cnt;
    exp_q.push_back(8'hC3);
    drive_frame(8'hC3, 1'b1, 4);
    chk("good_frame_rx_count", rx_cnt - r0, 1);
    chk("good_frame_rx_data", 32'(rx_data), 32'hC3);
    r0 = rx_cnt;
    b0 = brk_cnt;
    drive_frame(8'h3C, 1'b0, 4);
    chk("framing_no_rx_done", rx_cnt - r0, 0);
    chk("framing_no_break", brk_cnt - b0, 0);
    chk("framing_rx_data_held", 32'(rx_data), 32'hC3);

    // Short glitch at divisor 2
    do_reset(16'd2);
    r0 = rx_cnt;
    b0 = brk_cnt;
    rx_drv = 1'b0;
    cyc(4);
    rx_drv = 1'b1;
    cyc(200);
    chk("glitch_no_rx_done", rx_cnt - r0, 0);
    chk("glitch_no_break", brk_cnt - b0, 0);
    chk("final_rx_pending", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
